// File: rtl/snake_pkg.sv
// Shared direction codes, FSM state type and small direction helpers for the
// snake head mover and anything else that speaks the one-hot direction code.
package snake_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // True when exactly one direction bit is set.
  function automatic logic is_onehot(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

  // True when a and b point in opposite directions along the same axis.
  function automatic logic is_opposite(input logic [3:0] a, input logic [3:0] b);
    return ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

endpackage

// File: rtl/snake_head_mover_if.sv
// Bundle between the button/direction stage, the head mover and the
// body/pixel logic. XW/YW must equal $clog2 of the grid width/height used
// by the head mover instance attached to it.
interface snake_head_mover_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic [3:0]    direction;
  logic          restart;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [3:0]    cur_dir;
  logic          step;
  logic          dead;

  modport master (
    output direction, restart,
    input  head_x, head_y, cur_dir, step, dead
  );

  modport slave (
    input  direction, restart,
    output head_x, head_y, cur_dir, step, dead
  );
endinterface

// File: rtl/snake_head_mover_tick_gen.sv
// Move-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count for one cycle. Disabling it parks the count at zero so the
// first move after a start always takes a full period.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running count while enabled, wrapping at the terminal value.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);
endmodule

// File: rtl/snake_head_mover.sv
// Snake head mover: latches the requested direction (rejecting invalid codes
// and reversals), moves the head one cell per prescaler tick, and either wraps
// at the grid edge or stops in DEAD when the head would leave the grid.
module snake_head_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 12_500_000,
  parameter int WRAP     = 0,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input logic clk,
  input logic reset,
  snake_head_mover_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);

  state_t        state, state_n;
  logic [XW-1:0] head_x_q, head_x_n;
  logic [YW-1:0] head_y_q, head_y_n;
  logic [3:0]    cur_dir_q, cur_dir_n;
  logic [3:0]    pending_q, pending_n;
  logic          step_q, step_n;

  logic          tick;
  logic          tick_en;
  logic [XW:0]   x_wide;
  logic [YW:0]   y_wide;
  logic          off_x, off_y;
  logic [XW-1:0] x_wrapped;
  logic [YW-1:0] y_wrapped;

  // The move period only runs in RUN; a restart request stops it immediately.
  assign tick_en = (state == RUN) && !bus.restart;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (tick_en),
    .tick (tick)
  );

  // Candidate next cell from the pending direction, one bit wider so a step
  // left/up from 0 shows up as a borrow instead of aliasing to a valid cell.
  always_comb begin
    x_wide    = {1'b0, head_x_q};
    y_wide    = {1'b0, head_y_q};
    x_wrapped = head_x_q;
    y_wrapped = head_y_q;
    case (pending_q)
      DIR_LEFT: begin
        x_wide    = {1'b0, head_x_q} - (XW + 1)'(1);
        x_wrapped = X_MAX;
      end
      DIR_RIGHT: begin
        x_wide    = {1'b0, head_x_q} + (XW + 1)'(1);
        x_wrapped = '0;
      end
      DIR_UP: begin
        y_wide    = {1'b0, head_y_q} - (YW + 1)'(1);
        y_wrapped = Y_MAX;
      end
      DIR_DOWN: begin
        y_wide    = {1'b0, head_y_q} + (YW + 1)'(1);
        y_wrapped = '0;
      end
      default: begin
        x_wide = {1'b0, head_x_q};
        y_wide = {1'b0, head_y_q};
      end
    endcase
    off_x = x_wide > {1'b0, X_MAX};
    off_y = y_wide > {1'b0, Y_MAX};
  end

  // Next-state, direction latching and head update for the IDLE/RUN/DEAD FSM.
  always_comb begin
    state_n   = state;
    head_x_n  = head_x_q;
    head_y_n  = head_y_q;
    cur_dir_n = cur_dir_q;
    pending_n = pending_q;
    step_n    = 1'b0;

    if (bus.restart) begin
      state_n   = IDLE;
      head_x_n  = X_START;
      head_y_n  = Y_START;
      cur_dir_n = DIR_NONE;
      pending_n = DIR_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (is_onehot(bus.direction)) begin
            cur_dir_n = bus.direction;
            pending_n = bus.direction;
            state_n   = RUN;
          end
        end
        RUN: begin
          if (is_onehot(bus.direction) && !is_opposite(bus.direction, cur_dir_q)) begin
            pending_n = bus.direction;
          end
          if (tick) begin
            cur_dir_n = pending_q;
            if (!off_x && !off_y) begin
              head_x_n = x_wide[XW-1:0];
              head_y_n = y_wide[YW-1:0];
              step_n   = 1'b1;
            end else if (WRAP != 0) begin
              head_x_n = off_x ? x_wrapped : x_wide[XW-1:0];
              head_y_n = off_y ? y_wrapped : y_wide[YW-1:0];
              step_n   = 1'b1;
            end else begin
              state_n = DEAD;
            end
          end
        end
        DEAD: begin
          state_n = DEAD;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over everything, restart included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      head_x_q  <= X_START;
      head_y_q  <= Y_START;
      cur_dir_q <= DIR_NONE;
      pending_q <= DIR_NONE;
      step_q    <= 1'b0;
    end else begin
      state     <= state_n;
      head_x_q  <= head_x_n;
      head_y_q  <= head_y_n;
      cur_dir_q <= cur_dir_n;
      pending_q <= pending_n;
      step_q    <= step_n;
    end
  end

  assign bus.head_x  = head_x_q;
  assign bus.head_y  = head_y_q;
  assign bus.cur_dir = cur_dir_q;
  assign bus.step    = step_q;
  assign bus.dead    = (state == DEAD);
endmodule
